// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: requester count, ack
// timeout default, FSM state encoding and a one-hot helper.
package uart_tx_arbiter_pkg;

   localparam int unsigned NREQ_DEF        = 4;
   localparam int unsigned ACK_TIMEOUT_DEF = 16;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_ACK  = 2'd2,
      WAIT_DONE = 2'd3
   } arb_state_t;

   function automatic logic [3:0] id_to_onehot(input logic [1:0] id);
      logic [3:0] oh;
      oh     = '0;
      oh[id] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request scanning upward
// from ptr, wrapping modulo 4.
module rr_picker (
   input  logic [3:0] req,
   input  logic [1:0] ptr,
   output logic       valid,
   output logic [1:0] winner
);

   always_comb begin
      valid  = 1'b0;
      winner = ptr;
      for (int unsigned i = 0; i < 4; i++) begin
         // 2-bit addition wraps, giving the modulo-4 scan order for free
         if (!valid && req[ptr + 2'(i)]) begin
            valid  = 1'b1;
            winner = ptr + 2'(i);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding bytes from four requesters into a single UART
// transmitter, with an acknowledge timeout on the transmitter's busy flag.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int unsigned NREQ        = NREQ_DEF,
   parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic [NREQ-1:0]   req,
   input  logic [8*NREQ-1:0] req_data,
   output logic [NREQ-1:0]   grant,
   output logic [1:0]        active_id,
   output logic              Tx_WR,
   output logic [7:0]        Tx_DATA,
   input  logic              Tx_BUSY,
   output logic              tx_err,
   output logic              arb_busy
);

   localparam int unsigned          CNT_W    = $clog2(ACK_TIMEOUT + 1);
   localparam logic [CNT_W-1:0]     ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);

   arb_state_t       state;
   logic [1:0]       ptr;
   logic [CNT_W-1:0] ack_cnt;
   logic             pick_valid;
   logic [1:0]       pick_id;

   rr_picker u_picker (
      .req    (req),
      .ptr    (ptr),
      .valid  (pick_valid),
      .winner (pick_id)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         ptr       <= '0;
         ack_cnt   <= '0;
         grant     <= '0;
         active_id <= '0;
         Tx_WR     <= 1'b0;
         Tx_DATA   <= '0;
         tx_err    <= 1'b0;
         arb_busy  <= 1'b0;
      end else begin
         tx_err <= 1'b0;
         case (state)
            IDLE: begin
               if (en && !Tx_BUSY && pick_valid) begin
                  state     <= ISSUE;
                  active_id <= pick_id;
                  grant     <= id_to_onehot(pick_id);
                  Tx_WR     <= 1'b1;
                  Tx_DATA   <= req_data[8*pick_id +: 8];
                  arb_busy  <= 1'b1;
               end
            end
            ISSUE: begin
               Tx_WR   <= 1'b0;
               grant   <= '0;
               ptr     <= active_id + 2'd1;
               ack_cnt <= '0;
               state   <= WAIT_ACK;
            end
            WAIT_ACK: begin
               // busy wins over an expiring counter on the same edge
               if (Tx_BUSY) begin
                  state <= WAIT_DONE;
               end else if (ack_cnt == ACK_LAST) begin
                  tx_err   <= 1'b1;
                  arb_busy <= 1'b0;
                  ack_cnt  <= '0;
                  state    <= IDLE;
               end else begin
                  ack_cnt <= ack_cnt + 1'b1;
               end
            end
            WAIT_DONE: begin
               if (!Tx_BUSY) begin
                  arb_busy <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized
// transfers checked against a transaction-level round-robin model.
module tb_uart_tx_arbiter;

   localparam int ACK_TO = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        en;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  grant;
   logic [1:0]  active_id;
   logic        Tx_WR;
   logic [7:0]  Tx_DATA;
   logic        Tx_BUSY;
   logic        tx_err;
   logic        arb_busy;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int          model_ptr = 0;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.NREQ(4), .ACK_TIMEOUT(ACK_TO)) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .req       (req),
      .req_data  (req_data),
      .grant     (grant),
      .active_id (active_id),
      .Tx_WR     (Tx_WR),
      .Tx_DATA   (Tx_DATA),
      .Tx_BUSY   (Tx_BUSY),
      .tx_err    (tx_err),
      .arb_busy  (arb_busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Reference: first requester at or after p, modulo 4
   function automatic int rr_pick(input logic [3:0] r, input int p);
      for (int k = 0; k < 4; k++)
         if (r[(p + k) % 4]) return (p + k) % 4;
      return -1;
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_grant"},  32'(grant),     32'h0);
      check({tag, "_id"},     32'(active_id), 32'h0);
      check({tag, "_wr"},     32'(Tx_WR),     32'h0);
      check({tag, "_data"},   32'(Tx_DATA),   32'h0);
      check({tag, "_err"},    32'(tx_err),    32'h0);
      check({tag, "_busy"},   32'(arb_busy),  32'h0);
   endtask

   // One full transfer: issue, busy rises ack_delay cycles after Tx_WR, stays
   // up for busy_len cycles, then the arbiter must be idle again.
   task automatic do_xfer(input logic [3:0] r, input logic [31:0] d, input int ack_delay,
                          input int busy_len, input bit drop_en, output int got_id);
      int         ew;
      logic [7:0] eb;
      ew = rr_pick(r, model_ptr);
      eb = d[8*ew +: 8];
      req = r; req_data = d; en = 1'b1; Tx_BUSY = 1'b0;
      tick;
      got_id = int'(active_id);
      check("issue_wr",    32'(Tx_WR),     32'h1);
      check("issue_grant", 32'(grant),     32'(1) << ew);
      check("issue_id",    32'(active_id), 32'(ew));
      check("issue_data",  32'(Tx_DATA),   32'(eb));
      check("issue_busy",  32'(arb_busy),  32'h1);
      req = 4'($urandom); req_data = $urandom;
      for (int i = 1; i <= ack_delay; i++) begin
         tick;
         check("ack_wr_low",    32'(Tx_WR), 32'h0);
         check("ack_grant_low", 32'(grant), 32'h0);
         req = 4'($urandom);
         if (i == ack_delay) Tx_BUSY = 1'b1;
      end
      for (int i = 0; i < busy_len; i++) begin
         tick;
         check("done_busy",   32'(arb_busy), 32'h1);
         check("done_wr_low", 32'(Tx_WR),    32'h0);
         check("done_data",   32'(Tx_DATA),  32'(eb));
         if (drop_en && i == 0) en = 1'b0;
         req = 4'($urandom);
      end
      Tx_BUSY = 1'b0;
      req = drop_en ? 4'hF : 4'h0;
      tick;
      check("end_idle",  32'(arb_busy), 32'h0);
      check("end_wr",    32'(Tx_WR),    32'h0);
      check("end_data",  32'(Tx_DATA),  32'(eb));
      check("end_err",   32'(tx_err),   32'h0);
      model_ptr = (ew + 1) % 4;
   endtask

   task automatic do_timeout(input logic [3:0] r);
      int ew;
      int waited;
      ew = rr_pick(r, model_ptr);
      req = r; req_data = $urandom; en = 1'b1; Tx_BUSY = 1'b0;
      tick;
      check("to_issue_wr",    32'(Tx_WR), 32'h1);
      check("to_issue_grant", 32'(grant), 32'(1) << ew);
      req = 4'h0;
      waited = 0;
      while (tx_err !== 1'b1 && waited < 3 * ACK_TO) begin
         tick;
         waited++;
      end
      check("to_latency", 32'(waited),   32'(ACK_TO + 1));
      check("to_idle",    32'(arb_busy), 32'h0);
      tick;
      check("to_pulse",   32'(tx_err),   32'h0);
      model_ptr = (ew + 1) % 4;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int id;
      reset = 1'b1; en = 1'b0; req = '0; req_data = '0; Tx_BUSY = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("por");
      reset = 1'b0;
      tick;

      // Single requester 2, byte A5, busy two cycles after the write strobe
      do_xfer(4'b0100, 32'h00A5_0000, 2, 4, 1'b0, id);
      check("single_data_id", 32'(id), 32'd2);

      // No acknowledge: error pulse, then the next requester gets priority
      do_timeout(4'b1111);
      do_xfer(4'b1111, $urandom, 3, 5, 1'b0, id);

      // Busy transmitter while idle keeps requests pending
      Tx_BUSY = 1'b1; req = 4'b0010; en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick;
         check("held_wr",    32'(Tx_WR),    32'h0);
         check("held_grant", 32'(grant),    32'h0);
         check("held_busy",  32'(arb_busy), 32'h0);
      end
      do_xfer(4'b0010, $urandom, 1, 3, 1'b0, id);

      // Enable dropped mid-transfer: byte completes, nothing further issues
      do_xfer(4'b1111, $urandom, 2, 6, 1'b1, id);
      for (int i = 0; i < 8; i++) begin
         tick;
         check("en_off_wr",   32'(Tx_WR),    32'h0);
         check("en_off_busy", 32'(arb_busy), 32'h0);
      end
      do_xfer(4'b1111, $urandom, 2, 3, 1'b0, id);

      // Reset during WAIT_DONE clears outputs immediately and rewinds ptr
      req = 4'b0100; req_data = {8'h00, 8'h3C, 16'h0}; en = 1'b1; Tx_BUSY = 1'b0;
      tick;
      check("rst_pre_wr", 32'(Tx_WR), 32'h1);
      req = '0; Tx_BUSY = 1'b1;
      tick;
      tick;
      check("rst_pre_busy", 32'(arb_busy), 32'h1);
      reset = 1'b1;
      #1;
      check_reset_outputs("mid_rst");
      tick;
      reset = 1'b0; Tx_BUSY = 1'b0;
      model_ptr = 0;
      tick;

      // All requesters active: strict rotation from 0
      for (int k = 0; k < 5; k++) begin
         do_xfer(4'b1111, $urandom, 2, 10, 1'b0, id);
         check("rotate", 32'(id), 32'(k % 4));
      end
      do_xfer(4'b0001, $urandom, 1, 2, 1'b0, id);

      // Randomized traffic against the round-robin model
      for (int n = 0; n < 40; n++) begin
         logic [3:0] r;
         r = 4'($urandom_range(1, 15));
         if ($urandom_range(0, 7) == 0)
            do_timeout(r);
         else
            do_xfer(r, $urandom, int'($urandom_range(1, 8)), int'($urandom_range(1, 12)), 1'b0, id);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
